// File: rtl/divider_32_bit_pkg.sv
// Shared widths, state encoding and helpers for the iterative 32-bit divider.
package divider_32_bit_pkg;

    localparam int unsigned DIV_WIDTH = 32;
    localparam int unsigned DIV_CNT_W = 5;

    localparam logic [DIV_WIDTH-1:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
    localparam logic [DIV_CNT_W-1:0] DIV_CNT_LAST  = DIV_CNT_W'(DIV_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_e;

    // Two's-complement negation modulo 2^DIV_WIDTH.
    function automatic logic [DIV_WIDTH-1:0] div_neg(input logic [DIV_WIDTH-1:0] x);
        return DIV_WIDTH'(~x + DIV_WIDTH'(1));
    endfunction

    // Magnitude of x when treated as signed, otherwise x unchanged.
    function automatic logic [DIV_WIDTH-1:0] div_mag(input logic [DIV_WIDTH-1:0] x,
                                                     input logic                 sgn);
        return (sgn && x[DIV_WIDTH-1]) ? div_neg(x) : x;
    endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell used to build ripple arithmetic.
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);

    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

// File: rtl/subtractor_32_bit.sv
// Ripple subtractor: a - b computed as a + ~b + 1; borrow is the inverted carry-out.
module subtractor_32_bit
    import divider_32_bit_pkg::*;
(
    input  logic [DIV_WIDTH-1:0] a_i,
    input  logic [DIV_WIDTH-1:0] b_i,
    output logic [DIV_WIDTH-1:0] diff_o,
    output logic                 borrow_o
);

    logic [DIV_WIDTH:0] carry;

    assign carry[0] = 1'b1;

    for (genvar i = 0; i < DIV_WIDTH; i++) begin : g_bit
        full_adder u_fa (
            .a_i (a_i[i]),
            .b_i (~b_i[i]),
            .c_i (carry[i]),
            .s_o (diff_o[i]),
            .c_o (carry[i+1])
        );
    end

    assign borrow_o = ~carry[DIV_WIDTH];

endmodule

// File: rtl/divider_32_bit.sv
// Iterative restoring divider (DIV/DIVU): one quotient bit per clock, LO=quotient, HI=remainder.
// Signed operation is built only when SIGNED_DIV_EN is defined.
module divider_32_bit
    import divider_32_bit_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [DIV_WIDTH-1:0] dividend,
    input  logic [DIV_WIDTH-1:0] divisor,
    input  logic                 is_signed,
    output logic                 busy,
    output logic                 done,
    output logic [DIV_WIDTH-1:0] quotient,
    output logic [DIV_WIDTH-1:0] remainder,
    output logic                 div_zero
);

    div_state_e           state_q;
    logic [DIV_CNT_W-1:0] cnt_q;
    logic [DIV_WIDTH-1:0] rem_q;
    logic [DIV_WIDTH-1:0] quo_q;
    logic [DIV_WIDTH-1:0] dvs_q;
    logic                 busy_q;
    logic                 done_q;
    logic [DIV_WIDTH-1:0] quot_q;
    logic [DIV_WIDTH-1:0] remd_q;
    logic                 dz_q;
    logic                 zpend_q;

    // One restoring step: shift in the next dividend bit, then try the subtraction.
    logic [DIV_WIDTH:0]   shift_c;
    logic [DIV_WIDTH-1:0] diff_c;
    logic                 borrow_lo_c;
    logic                 borrow_c;
    logic [DIV_WIDTH-1:0] rem_d;
    logic [DIV_WIDTH-1:0] quo_d;

    assign shift_c = {rem_q, quo_q[DIV_WIDTH-1]};

    subtractor_32_bit u_sub (
        .a_i      (shift_c[DIV_WIDTH-1:0]),
        .b_i      (dvs_q),
        .diff_o   (diff_c),
        .borrow_o (borrow_lo_c)
    );

    // 33-bit borrow: the shifted-out top bit absorbs a low-word borrow.
    assign borrow_c = borrow_lo_c & ~shift_c[DIV_WIDTH];
    assign rem_d    = borrow_c ? shift_c[DIV_WIDTH-1:0] : diff_c;
    assign quo_d    = {quo_q[DIV_WIDTH-2:0], ~borrow_c};

    logic                 dvs_zero_c;
    logic [DIV_WIDTH-1:0] dvd_cap_c;
    logic [DIV_WIDTH-1:0] dvs_cap_c;
    logic [DIV_WIDTH-1:0] quot_fix_c;
    logic [DIV_WIDTH-1:0] remd_fix_c;

    assign dvs_zero_c = (divisor == '0);

`ifdef SIGNED_DIV_EN
    logic neg_quo_q;
    logic neg_rem_q;
    logic neg_quo_c;
    logic neg_rem_c;

    assign neg_quo_c  = is_signed & (dividend[DIV_WIDTH-1] ^ divisor[DIV_WIDTH-1]);
    assign neg_rem_c  = is_signed & dividend[DIV_WIDTH-1];
    // Divide-by-zero keeps the raw dividend so it can be returned unchanged.
    assign dvd_cap_c  = dvs_zero_c ? dividend : div_mag(dividend, is_signed);
    assign dvs_cap_c  = div_mag(divisor, is_signed);
    assign quot_fix_c = neg_quo_q ? div_neg(quo_d) : quo_d;
    assign remd_fix_c = neg_rem_q ? div_neg(rem_d) : rem_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else if (start && (state_q != RUN) && !zpend_q) begin
            neg_quo_q <= neg_quo_c;
            neg_rem_q <= neg_rem_c;
        end
    end
`else
    logic unused_is_signed_c;

    assign unused_is_signed_c = is_signed;
    assign dvd_cap_c          = dividend;
    assign dvs_cap_c          = divisor;
    assign quot_fix_c         = quo_d;
    assign remd_fix_c         = rem_d;
`endif

    // Control FSM with counter, working registers and registered results.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quot_q  <= '0;
            remd_q  <= '0;
            dz_q    <= 1'b0;
            zpend_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                RUN: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= DIV_CNT_W'(cnt_q + 1'b1);
                    if (cnt_q == DIV_CNT_LAST) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        quot_q  <= quot_fix_c;
                        remd_q  <= remd_fix_c;
                    end
                end
                default: begin
                    if ((state_q == DONE) && zpend_q) begin
                        // Divide-by-zero result, one cycle after capture.
                        zpend_q <= 1'b0;
                        done_q  <= 1'b1;
                        quot_q  <= DIV_BY_ZERO_Q;
                        remd_q  <= quo_q;
                        dz_q    <= 1'b1;
                    end else if (start) begin
                        cnt_q <= '0;
                        rem_q <= '0;
                        quo_q <= dvd_cap_c;
                        dvs_q <= dvs_cap_c;
                        dz_q  <= 1'b0;
                        if (dvs_zero_c) begin
                            state_q <= DONE;
                            zpend_q <= 1'b1;
                        end else begin
                            state_q <= RUN;
                            busy_q  <= 1'b1;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quot_q;
    assign remainder = remd_q;
    assign div_zero  = dz_q;

endmodule

// File: tb/tb_divider_32_bit.sv
// Self-checking bench for divider_32_bit; expected results queued at start, checked at done.
module tb_divider_32_bit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        is_signed;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_zero;

    typedef struct packed {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    divider_32_bit dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .is_signed (is_signed),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model_u(input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        if (b == 32'd0) begin
            e.q  = 32'hFFFF_FFFF;
            e.r  = a;
            e.dz = 1'b1;
        end else begin
            e.q  = a / b;
            e.r  = a % b;
            e.dz = 1'b0;
        end
        return e;
    endfunction

    // Drive a start for one edge; operands are then scrambled to expose any re-sampling.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                            input bit push, input exp_t e);
        dividend  = a;
        divisor   = b;
        is_signed = sgn;
        start     = 1'b1;
        if (push) sb.push_back(e);
        @(posedge clk); #1;
        start     = 1'b0;
        dividend  = $urandom;
        divisor   = $urandom;
        is_signed = 1'($urandom_range(0, 1));
    endtask

    // Wait (bounded) for done; optionally pulse start at cycles pa/pb while busy.
    task automatic wait_done(input string tag, input int exp_lat, input int pa, input int pb);
        int   lat    = 0;
        int   busy_n = 0;
        exp_t e;
        while (done !== 1'b1 && lat < 200) begin
            if (busy === 1'b1) busy_n++;
            start = ((pa != 0) && (lat == pa)) || ((pb != 0) && (lat == pb));
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        chk({tag, " done"}, 32'(done), 32'd1);
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, " busy_cycles"}, 32'(busy_n), (exp_lat == 32) ? 32'd32 : 32'd0);
        chk({tag, " sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, " quotient"}, quotient, e.q);
            chk({tag, " remainder"}, remainder, e.r);
            chk({tag, " div_zero"}, 32'(div_zero), 32'(e.dz));
        end
    endtask

    // done must be a single-cycle pulse with results held afterwards.
    task automatic pulse_end(input string tag);
        logic [31:0] q_prev;
        q_prev = quotient;
        @(posedge clk); #1;
        chk({tag, " done_pulse"}, 32'(done), 32'd0);
        chk({tag, " q_held"}, quotient, q_prev);
    endtask

    initial begin
        int   seen_done;
        exp_t e;
        reset     = 1'b1;
        start     = 1'b0;
        dividend  = '0;
        divisor   = '0;
        is_signed = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst quotient", quotient, 32'd0);
        chk("rst remainder", remainder, 32'd0);
        chk("rst div_zero", 32'(div_zero), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        start_op(32'd100, 32'd7, 1'b0, 1'b1, model_u(32'd100, 32'd7));
        wait_done("100/7", 32, 0, 0);
        pulse_end("100/7");

        start_op(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1, model_u(32'hFFFF_FFFF, 32'd1));
        wait_done("max/1", 32, 0, 0);
        pulse_end("max/1");

        start_op(32'd5, 32'd9, 1'b0, 1'b1, model_u(32'd5, 32'd9));
        wait_done("5/9", 32, 0, 0);
        pulse_end("5/9");

        start_op(32'h1234, 32'd0, 1'b0, 1'b1, model_u(32'h1234, 32'd0));
        wait_done("div0", 1, 0, 0);
        pulse_end("div0");

        start_op(32'd8, 32'd2, 1'b0, 1'b1, model_u(32'd8, 32'd2));
        wait_done("8/2", 32, 0, 0);
        pulse_end("8/2");

        start_op(32'd1000, 32'd3, 1'b0, 1'b1, model_u(32'd1000, 32'd3));
        wait_done("ignore_start", 32, 5, 20);
        pulse_end("ignore_start");

        // Back-to-back: second start issued in the done cycle of the first.
        start_op(32'd77, 32'd5, 1'b0, 1'b1, model_u(32'd77, 32'd5));
        wait_done("b2b first", 32, 0, 0);
        start_op(32'd123456789, 32'd1000, 1'b0, 1'b1, model_u(32'd123456789, 32'd1000));
        wait_done("b2b second", 32, 0, 0);
        pulse_end("b2b second");

        // Abort mid-run; on the reset edge a start is also presented and must lose.
        start_op(32'd999, 32'd4, 1'b0, 1'b0, model_u(32'd999, 32'd4));
        repeat (9) @(posedge clk);
        #1;
        reset    = 1'b1;
        start    = 1'b1;
        dividend = 32'd50;
        divisor  = 32'd5;
        @(posedge clk); #1;
        reset = 1'b0;
        start = 1'b0;
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort done", 32'(done), 32'd0);
        chk("abort quotient", quotient, 32'd0);
        chk("abort remainder", remainder, 32'd0);
        chk("abort div_zero", 32'(div_zero), 32'd0);
        seen_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) seen_done++;
        end
        chk("abort no_done", 32'(seen_done), 32'd0);

        start_op(32'hDEAD_BEEF, 32'h10, 1'b0, 1'b1, model_u(32'hDEAD_BEEF, 32'h10));
        wait_done("after_abort", 32, 0, 0);
        pulse_end("after_abort");

        for (int i = 0; i < 3; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = $urandom;
            b = $urandom >> $urandom_range(0, 28);
            if (b == 32'd0) b = 32'd3;
            start_op(a, b, 1'b0, 1'b1, model_u(a, b));
            wait_done("random", 32, 0, 0);
            pulse_end("random");
        end

`ifdef SIGNED_DIV_EN
        e = '{q: 32'hFFFF_FFFD, r: 32'hFFFF_FFFF, dz: 1'b0};
        start_op(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1, e);
        wait_done("sdiv -7/2", 32, 0, 0);
        pulse_end("sdiv -7/2");

        e = '{q: 32'h8000_0000, r: 32'd0, dz: 1'b0};
        start_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, e);
        wait_done("sdiv min/-1", 32, 0, 0);
        pulse_end("sdiv min/-1");

        e = '{q: 32'hFFFF_FFFF, r: 32'hFFFF_FFF0, dz: 1'b1};
        start_op(32'hFFFF_FFF0, 32'd0, 1'b1, 1'b1, e);
        wait_done("sdiv div0", 1, 0, 0);
        pulse_end("sdiv div0");
`else
        // is_signed is ignored: a signed request divides unsigned.
        e = model_u(32'hFFFF_FFF9, 32'd2);
        start_op(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1, e);
        wait_done("unsigned_only", 32, 0, 0);
        pulse_end("unsigned_only");
`endif

        chk("sb drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/divider_32_bit.md
# divider_32_bit

Iterative 32-bit restoring divider for the MIPS datapath, built from repeated subtraction, the inverse operation of the ripple adder. It serves DIV/DIVU: it accepts a dividend/divisor pair on a start pulse, retires one quotient bit per clock, and returns quotient (LO) and remainder (HI) with a one-cycle done pulse. It sits beside the ALU and feeds the HI/LO registers.

## Interface
- WIDTH, 32, operand/result width; iteration count equals WIDTH.
- clk  input  1  rising-edge clock, single clock domain.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE or DONE.
- dividend  input  WIDTH  numerator; captured on an accepted start.
- divisor  input  WIDTH  denominator; captured on an accepted start.
- is_signed  input  1  1 = DIV, 0 = DIVU; captured on an accepted start; ignored without SIGNED_DIV_EN.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse when results are valid.
- quotient  output  WIDTH  LO result; held until the next accepted start.
- remainder  output  WIDTH  HI result; held until the next accepted start.
- div_zero  output  1  set with done when divisor was 0; held with the results.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: start=1 captures the operands. If divisor≠0, go to RUN with iteration counter 0. If divisor=0, go to DONE.
- RUN: each cycle, shift {rem, quo} left one bit, bringing in the next dividend MSB.
  - Compute trial = rem − divisor with subtractor_32_bit, using a 33-bit borrow.
  - No borrow: rem = trial, quotient bit = 1. Borrow: rem is kept, quotient bit = 0.
  - After iteration WIDTH−1, go to DONE.
- DONE: done=1 for exactly one cycle, then return to IDLE. A start in DONE is accepted and goes directly to RUN or DONE, as in IDLE.
- start while busy is ignored. Operands are not re-sampled during RUN.
- Divide by zero: quotient = 0xFFFFFFFF, remainder = captured dividend, div_zero = 1.
- div_zero clears on the next accepted start.
- Arithmetic is unsigned modulo 2^WIDTH. Intermediate remainder is WIDTH+1 bits.

## Timing
- Reset values: state IDLE, busy 0, done 0, quotient 0, remainder 0, div_zero 0. The iteration counter and operand registers also clear.
- Start sampled at edge N, divisor≠0: busy high for edges N+1 … N+WIDTH. done and valid results appear after edge N+WIDTH (32 cycles).
- Divisor = 0: done appears after edge N+1.
- Back-to-back: a start during the done cycle produces the next done exactly WIDTH cycles later, with no idle bubble.
- Reset asserted mid-RUN: the operation aborts at that edge, all outputs return to reset values, and no done is produced.
- Reset has priority over start on the same edge.

## Configuration
- SIGNED_DIV_EN defined:
  - When is_signed=1, operands are converted to magnitudes at capture.
  - Result signs are registered: quotient is negated when the operand signs differ; remainder takes the dividend's sign.
  - The fixup is applied on the final RUN edge, so latency is unchanged.
  - 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0.
  - Signed divide by zero: remainder = original dividend; quotient = 0xFFFFFFFF.
- SIGNED_DIV_EN undefined: is_signed is ignored, all operations are unsigned, and no negation logic is built.

## Structure
- Shared package contents:
  - DIV_WIDTH = 32.
  - DIV_CNT_W = 5.
  - State encoding constants: IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2.
  - DIV_BY_ZERO_Q = 32'hFFFFFFFF.
- One sub-module, subtractor_32_bit: combinational a − b as a + ~b + 1, with a borrow output. It is built from the existing full_adder cells in ripple form and instantiated once for the trial subtraction.
- The FSM, counter and shift registers live in divider_32_bit.

## Test plan
- DIVU 100 / 7 → after 32 cycles, done=1 for one cycle, quotient=14, remainder=2, div_zero=0; busy high for exactly 32 cycles.
- DIVU 0xFFFFFFFF / 1 → quotient 0xFFFFFFFF, remainder 0. DIVU 5 / 9 → quotient 0, remainder 5.
- Divisor 0, dividend 0x1234 → done after 1 cycle, quotient 0xFFFFFFFF, remainder 0x1234, div_zero=1. A following start of 8 / 2 → div_zero=0, quotient=4.
- start pulsed at cycles 5 and 20 during a busy op → ignored; results match the first operands only. A start on the done cycle → the next done exactly 32 cycles later.
- reset at cycle 10 of RUN → busy=0, outputs zero, no done pulse. A new start afterward → correct result.
- SIGNED_DIV_EN, DIV −7 / 2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. DIV 0x80000000 / −1 → quotient 0x80000000, remainder 0.
